// File: rtl/asm_itl_ctrl_if.sv
// Signal bundle between the interleaver sequencer and its environment:
// block control, serial input stream, dual-RAM port and aligned output triple.
interface asm_itl_ctrl_if #(
    parameter int A_WIDTH = 16
);
    logic               start;
    logic [A_WIDTH-1:0] blk_len;
    logic [A_WIDTH-1:0] cfg_offset;
    logic               in_valid;
    logic               in_data;
    logic               in_ready;
    logic               ram_wdata;
    logic [A_WIDTH-1:0] ram_waddr;
    logic               ram_wen;
    logic [A_WIDTH-1:0] ram_id_offset;
    logic               ram_rdata;
    logic               ram_rdata_itl;
    logic               ram_rdata_ditl;
    logic               out_valid;
    logic               out_data;
    logic               out_data_itl;
    logic               out_data_ditl;
    logic [A_WIDTH-1:0] out_idx;
    logic               out_last;
    logic               busy;
    logic               done;

    modport master (
        input  start, blk_len, cfg_offset, in_valid, in_data,
               ram_rdata, ram_rdata_itl, ram_rdata_ditl,
        output in_ready, ram_wdata, ram_waddr, ram_wen, ram_id_offset,
               out_valid, out_data, out_data_itl, out_data_ditl,
               out_idx, out_last, busy, done
    );

    modport slave (
        output start, blk_len, cfg_offset, in_valid, in_data,
               ram_rdata, ram_rdata_itl, ram_rdata_ditl,
        input  in_ready, ram_wdata, ram_waddr, ram_wen, ram_id_offset,
               out_valid, out_data, out_data_itl, out_data_ditl,
               out_idx, out_last, busy, done
    );
endinterface

// File: rtl/asm_itl_ctrl.sv
// ASM interleaver RAM sequencer: loads one coded block serially, sweeps it back
// out and aligns the original/interleaved/deinterleaved bits to one strobe.
module asm_itl_ctrl #(
    parameter int A_WIDTH = 16,
    parameter int RD_LAT  = 3
) (
    input  logic           clk,
    input  logic           rst,
    asm_itl_ctrl_if.master bus
);

    typedef enum logic [2:0] {IDLE, LOAD, READ, FLUSH, DONE} state_t;

    state_t             state;
    logic [A_WIDTH-1:0] cnt;
    logic [A_WIDTH-1:0] len;
    logic [A_WIDTH-1:0] off;
    logic [A_WIDTH-1:0] idx;
    logic [RD_LAT-1:0]  vld_p;
    logic [RD_LAT-1:0]  last_p;
    logic               rdata_p1;
    logic               rdata_itl_p1;
    logic               cnt_end;
    logic               accept;
    logic               out_vld;

    assign cnt_end = (cnt == len - A_WIDTH'(1));
    assign accept  = (state == LOAD) && bus.in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            len   <= '0;
            off   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && (bus.blk_len != '0)) begin
                        len   <= bus.blk_len;
                        off   <= bus.cfg_offset;
                        cnt   <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (cnt_end) begin
                            cnt   <= '0;
                            state <= READ;
                        end else begin
                            cnt <= cnt + A_WIDTH'(1);
                        end
                    end
                end
                READ: begin
                    if (cnt_end) begin
                        cnt   <= '0;
                        state <= FLUSH;
                    end else begin
                        cnt <= cnt + A_WIDTH'(1);
                    end
                end
                FLUSH: begin
                    if (last_p[RD_LAT-1]) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Issue tokens: one per READ address, tap RD_LAT-1 lines up with the ditl bit
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p  <= '0;
            last_p <= '0;
            idx    <= '0;
        end else begin
            vld_p  <= {vld_p[RD_LAT-2:0], state == READ};
            last_p <= {last_p[RD_LAT-2:0], (state == READ) && cnt_end};
            if (state == IDLE)
                idx <= '0;
            else if (vld_p[RD_LAT-1])
                idx <= idx + A_WIDTH'(1);
        end
    end

    // Original and interleaved bits arrive one cycle early; delay them to the ditl bit
    always_ff @(posedge clk) begin
        rdata_p1     <= bus.ram_rdata;
        rdata_itl_p1 <= bus.ram_rdata_itl;
    end

    assign out_vld = vld_p[RD_LAT-1];

    assign bus.in_ready      = (state == LOAD);
    assign bus.ram_wen       = accept;
    assign bus.ram_wdata     = (state == LOAD) && bus.in_data;
    assign bus.ram_waddr     = cnt;
    assign bus.ram_id_offset = ((state == LOAD) || (state == READ) || (state == FLUSH)) ? off : '0;

    assign bus.out_valid     = out_vld;
    assign bus.out_data      = out_vld && rdata_p1;
    assign bus.out_data_itl  = out_vld && rdata_itl_p1;
    assign bus.out_data_ditl = out_vld && bus.ram_rdata_ditl;
    assign bus.out_last      = out_vld && last_p[RD_LAT-1];
    assign bus.out_idx       = idx;
    assign bus.busy          = (state != IDLE);
    assign bus.done          = (state == DONE);

endmodule

// File: tb/tb_asm_itl_ctrl.sv
// Randomized bench for asm_itl_ctrl: behavioural RAM/ROM around the DUT and a
// per-block list of expected triples built from the data and permutation tables.
module tb_asm_itl_ctrl;
    localparam int AW = 16;
    localparam int RL = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    asm_itl_ctrl_if #(.A_WIDTH(AW)) bus ();
    asm_itl_ctrl #(.A_WIDTH(AW), .RD_LAT(RL)) dut (.clk(clk), .rst(rst), .bus(bus));

    // RAM with permutation ROMs: orig/itl read after RL-1 cycles, ditl after RL
    logic          mem      [0:65535];
    logic [AW-1:0] rom_pi   [0:65535];
    logic [AW-1:0] rom_depi [0:65535];
    logic [AW-1:0] pa [1:RL];
    logic [AW-1:0] pr [1:RL];
    int            cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.ram_wen) mem[bus.ram_waddr] <= bus.ram_wdata;
        pa[1] <= bus.ram_waddr;
        pr[1] <= bus.ram_waddr + bus.ram_id_offset;
        for (int i = 2; i <= RL; i++) begin
            pa[i] <= pa[i-1];
            pr[i] <= pr[i-1];
        end
    end

    assign bus.ram_rdata      = mem[pa[RL-1]];
    assign bus.ram_rdata_itl  = mem[rom_pi[pr[RL-1]]];
    assign bus.ram_rdata_ditl = mem[rom_depi[pr[RL]]];

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Observation of every cycle while a block runs
    bit             mon_en = 1'b0;
    logic [AW-1:0]  wr_addr_q[$];
    bit             wr_data_q[$];
    logic [AW+3:0]  out_q[$];
    int             out_cyc_q[$];
    int             wr_cyc_last, done_cnt, done_cyc, viol_wen, viol_zero, viol_off;
    logic [AW-1:0]  cur_off;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.ram_wen) begin
                wr_addr_q.push_back(bus.ram_waddr);
                wr_data_q.push_back(bus.ram_wdata);
                wr_cyc_last = cyc;
            end
            if (bus.ram_wen !== (bus.in_valid && bus.in_ready)) viol_wen++;
            if (bus.out_valid) begin
                out_q.push_back({bus.out_idx, bus.out_last, bus.out_data,
                                 bus.out_data_itl, bus.out_data_ditl});
                out_cyc_q.push_back(cyc);
            end else if ({bus.out_data, bus.out_data_itl, bus.out_data_ditl, bus.out_last} != 4'b0) begin
                viol_zero++;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.ram_id_offset !== ((bus.busy && !bus.done) ? cur_off : AW'(0))) viol_off++;
        end
    end

    // mode 0: in_valid high, data k[0]; mode 1: in_valid every other cycle, data k[0];
    // mode 2: random data and random in_valid. rst_at>=0 resets at that READ address.
    task automatic run_block(input int n, input logic [AW-1:0] off, input int mode,
                             input int rst_at, input bit poke);
        bit            dat    [256];
        int            pi_t   [256];
        int            depi_t [256];
        int            a, s_cyc, acc, j, waitn;
        logic [AW-1:0] ra;
        logic [AW+3:0] e;

        a = (n % 13 == 0) ? 7 : 13;
        for (int k = 0; k < n; k++) begin
            dat[k]  = (mode == 2) ? 1'($urandom_range(0, 1)) : k[0];
            pi_t[k] = (a * k + 7) % n;
        end
        for (int k = 0; k < n; k++) depi_t[pi_t[k]] = k;
        for (int k = 0; k < n; k++) begin
            ra           = off + AW'(k);
            rom_pi[ra]   = AW'(pi_t[k]);
            rom_depi[ra] = AW'(depi_t[k]);
        end

        wr_addr_q.delete(); wr_data_q.delete(); out_q.delete(); out_cyc_q.delete();
        wr_cyc_last = 0; done_cnt = 0; done_cyc = 0;
        viol_wen = 0; viol_zero = 0; viol_off = 0;
        cur_off = off;
        mon_en  = 1'b1;

        bus.start = 1'b1; bus.blk_len = AW'(n); bus.cfg_offset = off;
        s_cyc = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.blk_len    = AW'($urandom_range(1, 500));
        bus.cfg_offset = AW'($urandom);

        acc = 0; j = 0;
        while (acc < n && j < 4 * n + 20) begin
            bus.in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (j % 2 == 0) : 1'($urandom_range(0, 1));
            bus.in_data  = dat[acc];
            bus.start    = poke && (j == 5);
            if (bus.in_valid && bus.in_ready) acc++;
            @(posedge clk); #1;
            j++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        check_eq("load_accepts", 32'(acc), 32'(n));

        if (rst_at >= 0) begin
            repeat (rst_at) @(posedge clk);
            #1;
            check_eq("pre_rst_addr", 32'(bus.ram_waddr), 32'(rst_at));
            mon_en = 1'b0;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check_eq("rst_busy",   32'(bus.busy), 32'(0));
            check_eq("rst_valid",  32'(bus.out_valid), 32'(0));
            check_eq("rst_offset", 32'(bus.ram_id_offset), 32'(0));
            check_eq("rst_ready",  32'(bus.in_ready), 32'(0));
            check_eq("rst_idx",    32'(bus.out_idx), 32'(0));
            return;
        end

        waitn = 0;
        while (done_cnt == 0 && waitn < n + RL + 20) begin
            bus.start = poke && (waitn == 2);
            @(posedge clk); #1;
            waitn++;
        end
        bus.start = 1'b0;
        check_eq("done_seen", 32'(done_cnt > 0), 32'(1));
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;

        check_eq("n_writes", 32'(wr_addr_q.size()), 32'(n));
        for (int k = 0; k < n && k < wr_addr_q.size(); k++)
            check_eq("write", 32'({wr_addr_q[k], wr_data_q[k]}), 32'({AW'(k), dat[k]}));
        check_eq("n_out", 32'(out_q.size()), 32'(n));
        for (int k = 0; k < n && k < out_q.size(); k++) begin
            e = {AW'(k), (k == n - 1), dat[k], dat[pi_t[k]], dat[depi_t[k]]};
            check_eq("triple", 32'(out_q[k]), 32'(e));
        end
        if (out_cyc_q.size() > 0) begin
            check_eq("first_lat", 32'(out_cyc_q[0] - wr_cyc_last), 32'(RL + 1));
            check_eq("contig", 32'(out_cyc_q[out_cyc_q.size() - 1] - out_cyc_q[0]), 32'(n - 1));
        end
        check_eq("done_lat", 32'(done_cyc - wr_cyc_last), 32'(n + RL + 1));
        if (mode == 0) check_eq("load_cycles", 32'(wr_cyc_last - s_cyc), 32'(n));
        if (mode == 1) check_eq("load_cycles", 32'(wr_cyc_last - s_cyc), 32'(2 * n - 1));
        check_eq("done_pulses", 32'(done_cnt), 32'(1));
        check_eq("wen_viol", 32'(viol_wen), 32'(0));
        check_eq("idle_zero", 32'(viol_zero), 32'(0));
        check_eq("offset_viol", 32'(viol_off), 32'(0));
        check_eq("busy_after", 32'(bus.busy), 32'(0));
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.blk_len = '0; bus.cfg_offset = '0;
        bus.in_valid = 1'b0; bus.in_data = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("reset_busy",   32'(bus.busy), 32'(0));
        check_eq("reset_ready",  32'(bus.in_ready), 32'(0));
        check_eq("reset_wen",    32'(bus.ram_wen), 32'(0));
        check_eq("reset_waddr",  32'(bus.ram_waddr), 32'(0));
        check_eq("reset_offset", 32'(bus.ram_id_offset), 32'(0));
        check_eq("reset_valid",  32'(bus.out_valid), 32'(0));
        check_eq("reset_done",   32'(bus.done), 32'(0));

        run_block(40, AW'(0), 0, -1, 1'b0);
        run_block(40, AW'(0), 1, -1, 1'b0);

        bus.start = 1'b1; bus.blk_len = '0; bus.cfg_offset = AW'(16'h0123);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check_eq("zero_len_busy", 32'(bus.busy), 32'(0));
        @(posedge clk); #1;
        check_eq("zero_len_ready", 32'(bus.in_ready), 32'(0));

        run_block(40, AW'(16'h0200), 2, -1, 1'b1);
        run_block(1,  AW'(16'h0100), 0, -1, 1'b0);
        run_block(40, AW'(16'h0300), 2, 20, 1'b0);
        run_block(8,  AW'(16'h0040), 2, -1, 1'b0);
        for (int r = 0; r < 3; r++)
            run_block($urandom_range(2, 60), AW'($urandom_range(0, 4000)), 2, -1, r == 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
